// File: rtl/wb_reg_file.sv
// MIPS write-back stage: selects WB_data, commits to a 32x32 register file with two combinational read ports and a retire counter.
// Writes land on the rising clk (define WB_BYPASS_EN for same-cycle write-through reads); reads have zero latency; no backpressure.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_WB_MemtoReg,
  input  logic              MEM_WB_RegWrite,
  input  logic [DATA_W-1:0] MEM_WB_RD,
  input  logic [DATA_W-1:0] MEM_WB_ALU_out,
  input  logic [ADDR_W-1:0] MEM_WB_WN,
  input  logic [ADDR_W-1:0] RN1,
  input  logic [ADDR_W-1:0] RN2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WB_data,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  retire_count_q;
  logic [CNT_W-1:0]  retire_count_d;
  logic              commit;

  always_comb begin
    WB_data = MEM_WB_MemtoReg ? MEM_WB_RD : MEM_WB_ALU_out;
    commit  = MEM_WB_RegWrite && (MEM_WB_WN != '0);
  end

  // Gating on commit keeps an unknown MemtoReg from reaching state when RegWrite is low.
  always_comb begin
    regs_d         = regs_q;
    retire_count_d = retire_count_q;
    if (commit) begin
      regs_d[MEM_WB_WN] = WB_data;
      retire_count_d    = retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      retire_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Index 0 and reset override any bypassed value.
  always_comb begin
    RD1 = regs_q[RN1];
    RD2 = regs_q[RN2];
`ifdef WB_BYPASS_EN
    if (commit && (RN1 == MEM_WB_WN)) RD1 = WB_data;
    if (commit && (RN2 == MEM_WB_WN)) RD2 = WB_data;
`endif
    if (rst || (RN1 == '0)) RD1 = '0;
    if (rst || (RN2 == '0)) RD2 = '0;
  end

  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: a write scoreboard is filled as commits are driven and drained through RD2 after each edge.
module tb_wb_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              MEM_WB_MemtoReg;
  logic              MEM_WB_RegWrite;
  logic [DATA_W-1:0] MEM_WB_RD;
  logic [DATA_W-1:0] MEM_WB_ALU_out;
  logic [ADDR_W-1:0] MEM_WB_WN;
  logic [ADDR_W-1:0] RN1;
  logic [ADDR_W-1:0] RN2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] WB_data;
  logic [CNT_W-1:0]  retire_count;

  wb_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MEM_WB_MemtoReg(MEM_WB_MemtoReg), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_RD(MEM_WB_RD), .MEM_WB_ALU_out(MEM_WB_ALU_out), .MEM_WB_WN(MEM_WB_WN),
    .RN1(RN1), .RN2(RN2), .RD1(RD1), .RD2(RD2),
    .WB_data(WB_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] val;
  } wr_t;

  wr_t              sb[$];
  logic [CNT_W-1:0] exp_count;
  int               n_checks = 0;
  int               n_pass   = 0;

  // Drives one MEM/WB cycle; commits are recorded in the scoreboard and counter model.
  task automatic set_wb(input logic we, input logic m2r, input logic [DATA_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [ADDR_W-1:0] wn);
    wr_t e;
    MEM_WB_RegWrite = we;
    MEM_WB_MemtoReg = m2r;
    MEM_WB_RD       = rd;
    MEM_WB_ALU_out  = alu;
    MEM_WB_WN       = wn;
    if (we && wn != '0) begin
      e.idx = wn;
      e.val = m2r ? rd : alu;
      sb.push_back(e);
      exp_count = exp_count + CNT_W'(1);
    end
  endtask

  task automatic idle();
    MEM_WB_RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    wr_t e;
    rst = 1'b1;
    RN1 = 5'd5;
    RN2 = 5'd31;
    MEM_WB_RegWrite = 1'b1;
    MEM_WB_MemtoReg = 1'b0;
    MEM_WB_RD       = '0;
    MEM_WB_ALU_out  = 32'h0000_AAAA;
    MEM_WB_WN       = 5'd5;
    exp_count = '0;
    #1;
    n_checks++; if (RD1 !== '0) $display("FAIL reset_rd1 got %h want %h", RD1, 32'h0); else n_pass++;
    n_checks++; if (RD2 !== '0) $display("FAIL reset_rd2 got %h want %h", RD2, 32'h0); else n_pass++;
    n_checks++; if (WB_data !== 32'h0000_AAAA) $display("FAIL reset_wb_data got %h want %h", WB_data, 32'h0000_AAAA); else n_pass++;
    @(negedge clk);
    n_checks++; if (RD1 !== '0) $display("FAIL reset_edge_write got %h want %h", RD1, 32'h0); else n_pass++;
    n_checks++; if (retire_count !== '0) $display("FAIL reset_edge_count got %0d want 0", retire_count); else n_pass++;
    rst = 1'b0;
    set_wb(1'b1, 1'b0, '0, 32'h0000_1234, 5'd5);
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL first_commit r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    n_checks++; if (RD1 !== 32'h0000_1234) $display("FAIL pre_reset_rd1 got %h want %h", RD1, 32'h0000_1234); else n_pass++;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_count = '0;
    n_checks++; if (RD1 !== '0) $display("FAIL async_reset_rd1 got %h want %h", RD1, 32'h0); else n_pass++;
    n_checks++; if (retire_count !== exp_count) $display("FAIL async_reset_count got %0d want %0d", retire_count, exp_count); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_write();
    wr_t e;
    @(negedge clk);
    set_wb(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd8);
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL alu_write r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    n_checks++; if (retire_count !== exp_count) $display("FAIL alu_write_count got %0d want %0d", retire_count, exp_count); else n_pass++;
  endtask

  task automatic test_mem_write();
    wr_t e;
    @(negedge clk);
    set_wb(1'b1, 1'b1, 32'h0000_00FF, 32'h5555_5555, 5'd31);
    #1;
    n_checks++; if (WB_data !== 32'h0000_00FF) $display("FAIL mem_wb_data got %h want %h", WB_data, 32'h0000_00FF); else n_pass++;
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL mem_write r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    n_checks++; if (retire_count !== exp_count) $display("FAIL mem_write_count got %0d want %0d", retire_count, exp_count); else n_pass++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    RN1 = '0;
    set_wb(1'b1, 1'b0, '0, 32'hFFFF_FFFF, 5'd0);
    #1;
    n_checks++; if (WB_data !== 32'hFFFF_FFFF) $display("FAIL zero_wb_data got %h want %h", WB_data, 32'hFFFF_FFFF); else n_pass++;
    n_checks++; if (RD1 !== '0) $display("FAIL zero_bypass_rd1 got %h want %h", RD1, 32'h0); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (RD1 !== '0) $display("FAIL zero_rd1 got %h want %h", RD1, 32'h0); else n_pass++;
    n_checks++; if (retire_count !== exp_count) $display("FAIL zero_count got %0d want %0d", retire_count, exp_count); else n_pass++;
  endtask

  task automatic test_bypass();
    wr_t              e;
    logic [DATA_W-1:0] pre_edge;
`ifdef WB_BYPASS_EN
    pre_edge = 32'h22;
`else
    pre_edge = 32'h11;
`endif
    @(negedge clk);
    set_wb(1'b1, 1'b0, '0, 32'h11, 5'd3);
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL bypass_setup r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    RN1 = 5'd3;
    set_wb(1'b1, 1'b0, '0, 32'h22, 5'd3);
    #1;
    n_checks++; if (RD1 !== pre_edge) $display("FAIL bypass_pre_edge got %h want %h", RD1, pre_edge); else n_pass++;
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL bypass_post_edge r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    set_wb(1'b0, 1'b0, '0, 32'h33, 5'd3);
    #1;
    n_checks++; if (RD1 !== 32'h22) $display("FAIL bypass_no_commit got %h want %h", RD1, 32'h22); else n_pass++;
  endtask

  task automatic test_x_memtoreg();
    @(negedge clk);
    RN1 = 5'd8;
    set_wb(1'b0, 1'bx, 32'h0BAD_0BAD, 32'h0BAD_0BA2, 5'd8);
    @(negedge clk);
    #1;
    n_checks++; if (RD1 !== 32'hDEAD_BEEF) $display("FAIL x_memtoreg_reg got %h want %h", RD1, 32'hDEAD_BEEF); else n_pass++;
    n_checks++; if (retire_count !== exp_count) $display("FAIL x_memtoreg_count got %0d want %0d", retire_count, exp_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr_t e;
    @(negedge clk);
    set_wb(1'b1, 1'b0, '0, 32'hA1A1_A1A1, 5'd9);
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL b2b_first r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    set_wb(1'b1, 1'b1, 32'hB2B2_B2B2, 32'h0, 5'd9);
    @(negedge clk);
    idle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      RN2 = e.idx;
      #1;
      n_checks++; if (RD2 !== e.val) $display("FAIL b2b_last_wins r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
    end
    n_checks++; if (retire_count !== exp_count) $display("FAIL b2b_count got %0d want %0d", retire_count, exp_count); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    wr_t e;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    sb.delete();
    exp_count = '0;
    for (int i = 0; i < 17; i++) begin
      set_wb(1'b1, 1'b0, '0, 32'(100 + i), 5'd1);
      @(negedge clk);
      idle();
      if (i % 2 == 1) begin
        set_wb(1'b0, 1'b0, '0, 32'hFFFF_0000, 5'd1);
        @(negedge clk);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        RN2 = e.idx;
        #1;
        n_checks++; if (RD2 !== e.val) $display("FAIL wrap_write r%0d got %h want %h", e.idx, RD2, e.val); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (retire_count !== exp_count) $display("FAIL wrap_at_16 got %0d want %0d", retire_count, exp_count); else n_pass++;
      end
    end
    n_checks++; if (retire_count !== exp_count) $display("FAIL wrap_final got %0d want %0d", retire_count, exp_count); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_write();
    test_mem_write();
    test_zero_reg();
    test_bypass();
    test_x_memtoreg();
    test_back_to_back();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
